gate_sequencer: RTL and testbench

Self-checking stimulus controller for a 2-input combinational gate (the `and_gate` block and its siblings) on iCE40 boards. On a start request it walks the gate through all four input combinations, holds each long enough to settle and be seen on LEDs, samples the gate output, and compares it against a parameterised truth table. It then reports a per-vector fail mask and an overall pass flag. It sits between board-level buttons/LEDs and the gate under test, replacing the simulation-only testbench sequencing with synthesizable hardware.

---
 rtl/gate_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_gate_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_sequencer
// Purpose  : Synthesizable self-test sequencer for a 2-input combinational
//            gate. On a start request it applies all four input vectors
//            (00, 01, 10, 11), holds each for HOLD_CYCLES+1 cycles, samples
//            the gate output in the last cycle of each vector and compares
//            it with TRUTH_TABLE. It then reports a per-vector fail mask and
//            an overall pass flag.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            start        - run request, accepted only while idle
//            a_o, b_o     - gate inputs under test
//            s_i          - gate output (sampled directly)
//            busy         - run in progress (acceptance through DONE)
//            vec_idx      - index {a_o,b_o} of the applied vector
//            done         - one-cycle end-of-run pulse
//            result_valid - results below belong to a completed run
//            pass         - last run had no mismatches
//            fail_mask    - bit i set when vector i mismatched
// Revision : 1.0 - initial release
// ============================================================================
module gate_sequencer #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] TRUTH_TABLE = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic       s_i,
  output logic       busy,
  output logic [1:0] vec_idx,
  output logic       done,
  output logic       result_valid,
  output logic       pass,
  output logic [3:0] fail_mask
);

  // Hold counter counts HOLD_CYCLES-1 down to 0, so it needs enough bits
  // for HOLD_CYCLES-1 and at least one bit.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("gate_sequencer: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       mask_q, mask_d;      // working mismatch mask
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rv_q, rv_d;
  logic             pass_q, pass_d;
  logic [3:0]       fm_q, fm_d;

  logic             w_mismatch;
  logic [3:0]       w_mask_upd;
  logic [1:0]       w_vec_next;

  // Mismatch of the vector currently held; only consumed in SAMPLE.
  assign w_mismatch = s_i ^ TRUTH_TABLE[vec_q];
  assign w_mask_upd = mask_q | ({3'b000, w_mismatch} << vec_q);
  assign w_vec_next = vec_q + 2'd1;

  // Every output is a register; the next-state logic computes the output
  // values for the state being entered so they line up with the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rv_d    = rv_q;
    pass_d  = pass_q;
    fm_d    = fm_q;

    case (state_q)
      S_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        vec_d  = 2'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_APPLY;
          cnt_d   = RELOAD;
          mask_d  = 4'b0000;
          rv_d    = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_APPLY: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        mask_d = w_mask_upd;
        if (vec_q == 2'd3) begin
          // The final vector's result is folded in on the same edge that
          // publishes the results.
          state_d = S_DONE;
          vec_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          done_d  = 1'b1;
          fm_d    = w_mask_upd;
          pass_d  = (w_mask_upd == 4'b0000);
          rv_d    = 1'b1;
        end else begin
          state_d = S_APPLY;
          vec_d   = w_vec_next;
          cnt_d   = RELOAD;
          a_d     = w_vec_next[1];
          b_d     = w_vec_next[0];
        end
      end

      S_DONE: begin
        // start is not looked at here, so a held start is accepted in the
        // IDLE cycle that follows.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      mask_q  <= 4'b0000;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      pass_q  <= 1'b0;
      fm_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      pass_q  <= pass_d;
      fm_q    <= fm_d;
    end
  end

  assign a_o          = a_q;
  assign b_o          = b_q;
  assign busy         = busy_q;
  assign vec_idx      = vec_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign pass         = pass_q;
  assign fail_mask    = fm_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sequencer
// Purpose  : Self-checking bench for gate_sequencer. A gate model driven by a
//            truth-table variable feeds s_i; expected waveforms and results
//            are derived from the cycle offset after the accepting edge and
//            from a per-vector comparison of gate and reference tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sequencer;

  localparam int         HC  = 4;
  localparam logic [3:0] REF = 4'b1000;
  localparam int         RUN = 4 * (HC + 1);   // edge offset of DONE entry

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a_o, b_o, s_i, busy, done, result_valid, pass;
  logic [1:0] vec_idx;
  logic [3:0] fail_mask;
  logic [3:0] gate_tt = 4'b1000;

  // Second instance: XOR reference table, shortest hold.
  logic       start2 = 1'b0;
  logic       a2, b2, s2, busy2, done2, rv2, pass2;
  logic [1:0] vec2;
  logic [3:0] fm2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign s_i = gate_tt[{a_o, b_o}];
  assign s2  = a2 ^ b2;

  gate_sequencer #(.HOLD_CYCLES(HC), .TRUTH_TABLE(REF)) dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o), .s_i(s_i),
    .busy(busy), .vec_idx(vec_idx), .done(done), .result_valid(result_valid),
    .pass(pass), .fail_mask(fail_mask)
  );

  gate_sequencer #(.HOLD_CYCLES(1), .TRUTH_TABLE(4'b0110)) dut_x (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .s_i(s2),
    .busy(busy2), .vec_idx(vec2), .done(done2), .result_valid(rv2),
    .pass(pass2), .fail_mask(fm2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result: a vector fails when the gate disagrees with REF.
  function automatic logic [3:0] model_mask(input logic [3:0] g);
    logic [3:0] m;
    m = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      if (g[v] != REF[v]) m[v] = 1'b1;
    end
    return m;
  endfunction

  // One complete run. Must be entered at a negedge with the DUT idle.
  // mode 0: single start pulse; 1: random start toggling while busy;
  // 2: start left high throughout.
  task automatic run(input string nm, input logic [3:0] g, input int mode);
    logic [3:0] em;
    em = model_mask(g);
    gate_tt = g;
    start   = 1'b1;
    @(posedge clk);                       // accepting edge E0
    for (int k = 0; k <= RUN + 1; k++) begin
      @(negedge clk);
      if (mode == 0) start = 1'b0;
      if (mode == 1) start = (k < RUN) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 0) begin
        chk({nm, " rv_cleared"}, {31'd0, result_valid}, 32'd0);
        chk({nm, " pass_cleared"}, {31'd0, pass}, 32'd0);
      end
      if (k < RUN) begin
        chk({nm, " ab"}, {30'd0, a_o, b_o}, k / (HC + 1));
        chk({nm, " vec_idx"}, {30'd0, vec_idx}, k / (HC + 1));
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        chk({nm, " done_low"}, {31'd0, done}, 32'd0);
      end else if (k == RUN) begin
        chk({nm, " done"}, {31'd0, done}, 32'd1);
        chk({nm, " busy_done"}, {31'd0, busy}, 32'd1);
        chk({nm, " ab_done"}, {30'd0, a_o, b_o}, 32'd0);
        chk({nm, " fail_mask"}, {28'd0, fail_mask}, {28'd0, em});
        chk({nm, " pass"}, {31'd0, pass}, {31'd0, (em == 4'b0000)});
        chk({nm, " result_valid"}, {31'd0, result_valid}, 32'd1);
      end else begin
        chk({nm, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, " idle_done"}, {31'd0, done}, 32'd0);
        chk({nm, " hold_mask"}, {28'd0, fail_mask}, {28'd0, em});
        chk({nm, " hold_rv"}, {31'd0, result_valid}, 32'd1);
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] gate;
    logic [3:0] exp_mask;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"stuck0", 4'b0000, 4'b1000, 1'b0};
    tbl[1] = '{"stuck1", 4'b1111, 4'b0111, 1'b0};
    tbl[2] = '{"nand",   4'b0111, 4'b1111, 1'b0};
    tbl[3] = '{"or",     4'b1110, 4'b0110, 1'b0};
    tbl[4] = '{"and",    4'b1000, 4'b0000, 1'b1};

    // Reset state.
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset outs", {20'd0, a_o, b_o, vec_idx, done, result_valid, pass, fail_mask},
        32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle no start", {31'd0, busy}, 32'd0);

    // Table-driven runs, including the fixed result of each table entry.
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].name, tbl[i].gate, 0);
      chk({tbl[i].name, " tbl_mask"}, {28'd0, fail_mask}, {28'd0, tbl[i].exp_mask});
      chk({tbl[i].name, " tbl_pass"}, {31'd0, pass}, {31'd0, tbl[i].exp_pass});
    end

    // Randomized gates with start chatter during busy.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run("rand", 4'($urandom), 1);
    end

    // Start held permanently: back-to-back runs with one idle cycle.
    run("held0", 4'b1000, 2);
    run("held1", 4'b0001, 2);
    run("held2", 4'b1000, 2);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset during vector 2 of a passing-results state.
    gate_tt = 4'b1000;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 2 * (HC + 1) + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset ab", {30'd0, a_o, b_o}, 32'd2);
    chk("pre-reset rv", {31'd0, result_valid}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async reset outs",
        {19'd0, busy, a_o, b_o, vec_idx, done, result_valid, pass, fail_mask}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (RUN + 4) @(negedge clk);
    chk("post-reset idle", {29'd0, busy, done, result_valid}, 32'd0);
    run("after_reset", 4'b1000, 0);

    // XOR instance: done after 4*(1+1) edges, pass expected.
    start2 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (k < 8) chk("xor ab", {30'd0, a2, b2}, k / 2);
      if (k < 8) chk("xor done_low", {31'd0, done2}, 32'd0);
    end
    chk("xor done", {31'd0, done2}, 32'd1);
    chk("xor pass", {31'd0, pass2}, 32'd1);
    chk("xor mask", {28'd0, fm2}, 32'd0);
    chk("xor rv", {31'd0, rv2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
